// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: req/ack fetch into IR, then register fields and immediate.
// Define IFD_ILLEGAL_CHECK_EN to fault on unknown opcodes or bad R-type funct7.

module instr_fetch_decode #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_start,
    input  logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic            instr_valid,
    output logic            fetch_fault,
    output logic            busy
);

    localparam logic [31:0] LP_NOP = 32'h00000013;
    localparam logic [7:0]  LP_MAX = 8'(MAX_WAIT);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DECODE,
        S_HOLD
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic            r_req;
    logic [XLEN-1:0] r_addr;
    logic [31:0]     r_ir;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [XLEN-1:0] r_imm;
    logic            r_valid;
    logic            r_fault;
    logic            r_busy;

    logic [6:0]      w_op;
    logic            w_is_i;
    logic            w_is_s;
    logic            w_is_b;
    logic            w_is_u;
    logic            w_is_j;
    logic [XLEN-1:0] w_imm;

    assign w_op   = r_ir[6:0];
    assign w_is_i = (w_op == OP_IMM) || (w_op == OP_LOAD) || (w_op == OP_JALR);
    assign w_is_s = (w_op == OP_STORE);
    assign w_is_b = (w_op == OP_BR);
    assign w_is_u = (w_op == OP_LUI) || (w_op == OP_AUIPC);
    assign w_is_j = (w_op == OP_JAL);

    always_comb begin
        w_imm = '0;
        unique case (1'b1)
            w_is_i: w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
            w_is_s: w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            w_is_b: w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7],
                             r_ir[30:25], r_ir[11:8], 1'b0};
            w_is_u: w_imm = {{(XLEN-32){r_ir[31]}}, r_ir[31:12], 12'b0};
            w_is_j: w_imm = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12],
                             r_ir[20], r_ir[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

`ifdef IFD_ILLEGAL_CHECK_EN
    logic w_legal;
    assign w_legal = (w_is_i || w_is_s || w_is_b || w_is_u || w_is_j) ||
                     ((w_op == OP_R) &&
                      ((r_ir[31:25] == 7'b0000000) || (r_ir[31:25] == 7'b0100000)));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_ir     <= LP_NOP;
            r_opcode <= LP_NOP[6:0];
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_HOLD: begin
                    if (fetch_start) begin
                        r_valid <= 1'b0;
                        if (pc[1:0] != 2'b00) begin
                            r_fault <= 1'b1;
                            r_state <= S_HOLD;
                        end else begin
                            r_fault <= 1'b0;
                            r_addr  <= pc;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack on the final allowed cycle still wins over the timeout
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end else if (r_cnt + 8'd1 == LP_MAX) begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    r_opcode <= r_ir[6:0];
                    r_funct3 <= r_ir[14:12];
                    r_funct7 <= r_ir[31:25];
                    r_rd     <= r_ir[11:7];
                    r_rs1    <= r_ir[19:15];
                    r_rs2    <= r_ir[24:20];
                    r_imm    <= w_imm;
                    r_busy   <= 1'b0;
                    r_state  <= S_HOLD;
`ifdef IFD_ILLEGAL_CHECK_EN
                    if (w_legal) r_valid <= 1'b1;
                    else         r_fault <= 1'b1;
`else
                    r_valid <= 1'b1;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr       = r_ir;
    assign opcode      = r_opcode;
    assign funct3      = r_funct3;
    assign funct7      = r_funct7;
    assign rd          = r_rd;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign imm         = r_imm;
    assign instr_valid = r_valid;
    assign fetch_fault = r_fault;
    assign busy        = r_busy;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Testbench for instr_fetch_decode: directed cases plus randomized fetches
// checked against a behavioural model of IR, decoded fields and faults.

module tb_instr_fetch_decode;

    localparam int XLEN     = 64;
    localparam int MAX_WAIT = 15;
    localparam logic [31:0] NOP = 32'h00000013;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_start;
    logic [XLEN-1:0] pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            instr_valid;
    logic            fetch_fault;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_ir   = NOP;
    logic [31:0] m_dec  = NOP;
    logic [63:0] m_addr = '0;
    logic [63:0] m_imm  = '0;

    instr_fetch_decode #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        longint v;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [19:0] u20;
        logic [20:0] j21;
        v = 0;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                i12 = w[31:20];
                v = longint'($signed(i12));
            end
            7'b0100011: begin
                i12 = {w[31:25], w[11:7]};
                v = longint'($signed(i12));
            end
            7'b1100011: begin
                b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                v = longint'($signed(b13));
            end
            7'b0110111, 7'b0010111: begin
                u20 = w[31:12];
                v = longint'($signed(u20)) * 4096;
            end
            7'b1101111: begin
                j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                v = longint'($signed(j21));
            end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit ref_valid(input logic [31:0] w);
`ifdef IFD_ILLEGAL_CHECK_EN
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111: return 1'b1;
            7'b0110011: return (w[31:25] == 7'b0000000) || (w[31:25] == 7'b0100000);
            default: return 1'b0;
        endcase
`else
        return (w == w);
`endif
    endfunction

    task automatic run_fetch(input logic [63:0] a, input logic [31:0] w,
                             input int d, input bit junk, input string tag);
        bit ok;
        bit ev;
        ok = (d < MAX_WAIT);
        @(negedge clk);
        fetch_start = 1'b1;
        pc = a;
        imem_ack = 1'b0;
        @(negedge clk);
        fetch_start = 1'b0;
        n_chk++;
        if (imem_req !== 1'b1 || busy !== 1'b1)
            $display("FAIL %s req_state: req=%0b busy=%0b want 1 1", tag, imem_req, busy);
        else n_pass++;
        n_chk++;
        if (imem_addr !== a)
            $display("FAIL %s addr: got %h want %h", tag, imem_addr, a);
        else n_pass++;
        n_chk++;
        if (fetch_fault !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL %s clear: fault=%0b valid=%0b want 0 0", tag, fetch_fault, instr_valid);
        else n_pass++;
        m_addr = a;
        imem_ack = junk;
        imem_rdata = ~w;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (ok && i == d) begin
                imem_ack = 1'b1;
                imem_rdata = w;
            end
            if (!ok && i == MAX_WAIT - 1) begin
                n_chk++;
                if (imem_req !== 1'b1)
                    $display("FAIL %s req_last: got %0b want 1", tag, imem_req);
                else n_pass++;
            end
            @(negedge clk);
            imem_ack = 1'b0;
            if (ok && i == d) break;
        end
        if (ok) begin
            m_ir = w;
            n_chk++;
            if (instr !== w || instr_valid !== 1'b0 || imem_req !== 1'b0)
                $display("FAIL %s capture: ir=%h valid=%0b req=%0b want %h 0 0",
                         tag, instr, instr_valid, imem_req, w);
            else n_pass++;
            @(negedge clk);
            m_dec = w;
            m_imm = ref_imm(w);
            ev = ref_valid(w);
            n_chk++;
            if (instr_valid !== ev || fetch_fault !== !ev || busy !== 1'b0)
                $display("FAIL %s done: valid=%0b fault=%0b busy=%0b want %0b %0b 0",
                         tag, instr_valid, fetch_fault, busy, ev, !ev);
            else n_pass++;
        end else begin
            n_chk++;
            if (imem_req !== 1'b0 || fetch_fault !== 1'b1 || busy !== 1'b0 ||
                instr_valid !== 1'b0)
                $display("FAIL %s timeout: req=%0b fault=%0b busy=%0b valid=%0b want 0 1 0 0",
                         tag, imem_req, fetch_fault, busy, instr_valid);
            else n_pass++;
            n_chk++;
            if (instr !== m_ir)
                $display("FAIL %s ir_kept: got %h want %h", tag, instr, m_ir);
            else n_pass++;
        end
        n_chk++;
        if (opcode !== m_dec[6:0] || funct3 !== m_dec[14:12] || funct7 !== m_dec[31:25] ||
            rd !== m_dec[11:7] || rs1 !== m_dec[19:15] || rs2 !== m_dec[24:20])
            $display("FAIL %s fields: got %h/%h/%h/%0d/%0d/%0d from %h",
                     tag, opcode, funct3, funct7, rd, rs1, rs2, m_dec);
        else n_pass++;
        n_chk++;
        if (imm !== m_imm)
            $display("FAIL %s imm: got %h want %h", tag, imm, m_imm);
        else n_pass++;
    endtask

    task automatic run_misaligned(input logic [63:0] a, input string tag);
        @(negedge clk);
        fetch_start = 1'b1;
        pc = a;
        @(negedge clk);
        fetch_start = 1'b0;
        n_chk++;
        if (imem_req !== 1'b0 || fetch_fault !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s misalign: req=%0b fault=%0b valid=%0b busy=%0b want 0 1 0 0",
                     tag, imem_req, fetch_fault, instr_valid, busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b0 || imem_addr !== m_addr || instr !== m_ir)
            $display("FAIL %s misalign_hold: req=%0b addr=%h ir=%h want 0 %h %h",
                     tag, imem_req, imem_addr, instr, m_addr, m_ir);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        fetch_start = 1'b0;
        pc = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (instr !== NOP || instr_valid !== 1'b0 || imem_req !== 1'b0 || imm !== 64'h0)
            $display("FAIL reset: ir=%h valid=%0b req=%0b imm=%h want %h 0 0 0",
                     instr, instr_valid, imem_req, imm, NOP);
        else n_pass++;
        n_chk++;
        if (opcode !== 7'b0010011 || rd !== 5'd0 || funct7 !== 7'd0 ||
            fetch_fault !== 1'b0 || busy !== 1'b0 || imem_addr !== 64'h0)
            $display("FAIL reset_fields: op=%b rd=%0d f7=%b fault=%0b busy=%0b addr=%h",
                     opcode, rd, funct7, fetch_fault, busy, imem_addr);
        else n_pass++;
    endtask

    task automatic test_sub;
        run_fetch(64'h100, 32'h40B50533, 0, 1'b0, "sub");
        n_chk++;
        if (opcode !== 7'b0110011 || funct7 !== 7'b0100000 || rd !== 5'd10 ||
            rs1 !== 5'd10 || rs2 !== 5'd11 || imm !== 64'h0 || instr_valid !== 1'b1)
            $display("FAIL sub_fields: op=%b f7=%b rd=%0d rs1=%0d rs2=%0d imm=%h valid=%0b",
                     opcode, funct7, rd, rs1, rs2, imm, instr_valid);
        else n_pass++;
    endtask

    task automatic test_imm;
        run_fetch(64'h104, 32'hFFC10113, 1, 1'b0, "addi");
        n_chk++;
        if (imm !== 64'hFFFFFFFFFFFFFFFC)
            $display("FAIL addi_imm: got %h want FFFFFFFFFFFFFFFC", imm);
        else n_pass++;
        run_fetch(64'h108, 32'hFE000EE3, 2, 1'b1, "beq");
        n_chk++;
        if (imm !== 64'hFFFFFFFFFFFFFFFC)
            $display("FAIL beq_imm: got %h want FFFFFFFFFFFFFFFC", imm);
        else n_pass++;
    endtask

    task automatic test_misaligned;
        run_misaligned(64'h102, "pc102");
    endtask

    task automatic test_timeout;
        run_fetch(64'h200, 32'h00A00093, MAX_WAIT, 1'b0, "timeout");
        run_fetch(64'h204, 32'h00A00093, 0, 1'b0, "after_to");
        run_fetch(64'h208, 32'h123450B7, MAX_WAIT - 1, 1'b0, "ack_last");
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        fetch_start = 1'b1;
        pc = 64'h300;
        @(negedge clk);
        fetch_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_ir = NOP;
        m_dec = NOP;
        m_addr = '0;
        m_imm = '0;
        n_chk++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || instr !== NOP)
            $display("FAIL rst_wait: req=%0b busy=%0b ir=%h want 0 0 %h",
                     imem_req, busy, instr, NOP);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h0000A0B7;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b0 || instr !== NOP || instr_valid !== 1'b0 ||
            busy !== 1'b0 || imem_addr !== 64'h0)
            $display("FAIL rst_ack: req=%0b ir=%h valid=%0b busy=%0b addr=%h",
                     imem_req, instr, instr_valid, busy, imem_addr);
        else n_pass++;
    endtask

    task automatic test_illegal;
        run_fetch(64'h400, 32'h0000007F, 0, 1'b0, "illegal");
`ifdef IFD_ILLEGAL_CHECK_EN
        n_chk++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL illegal_flag: fault=%0b valid=%0b want 1 0", fetch_fault, instr_valid);
        else n_pass++;
`endif
        run_fetch(64'h404, 32'h02B50533, 1, 1'b0, "mul_f7");
    endtask

    task automatic test_random;
        logic [6:0] ops [9];
        logic [31:0] w;
        logic [63:0] a;
        logic [31:0] r;
        int d;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 8)];
            if (w[6:0] == 7'b0110011 && $urandom_range(0, 1) == 1)
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            r = $urandom;
            a = {r, 32'h0};
            r = $urandom;
            a = a | {32'h0, r};
            if ($urandom_range(0, 7) == 0) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                run_misaligned(a, "rnd_mis");
            end else begin
                a[1:0] = 2'b00;
                d = (($urandom_range(0, 5) == 0) ? $urandom_range(MAX_WAIT - 1, MAX_WAIT + 2)
                                                 : $urandom_range(0, 4));
                run_fetch(a, w, d, 1'($urandom_range(0, 1)), "rnd");
            end
        end
    endtask

    initial begin
        test_reset;
        test_sub;
        test_imm;
        test_misaligned;
        test_timeout;
        test_illegal;
        test_random;
        test_reset_mid_wait;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
